fe_fifo_reader: RTL and testbench

Drains the front-end capture FIFO (entries of DATA/STAT/TIME records written by the USB sniffer front end) and serializes each entry into a byte stream for host readout over the USB register interface. Sits between the FIFO read port and the USB data-read path. Handles the FIFO read latency, entry decoding, multi-byte emission with ready/valid backpressure, and entry/byte accounting.

---
 rtl/fe_fifo_reader_pkg.sv | 33 +++
 rtl/fe_entry_encoder.sv | 45 ++++
 rtl/fe_fifo_reader.sv | 127 ++++++++++++
 tb/tb_fe_fifo_reader.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_fifo_reader_pkg.sv
// Shared definitions for the front-end capture FIFO reader: entry layout,
// command codes, reader FSM states and per-command byte counts.
package fe_fifo_reader_pkg;

    localparam int ENTRY_W = 18;
    localparam int CMD_MSB = 17;
    localparam int CMD_LSB = 16;

    typedef enum logic [1:0] {
        FE_FIFO_CMD_DATA = 2'b00,
        FE_FIFO_CMD_TIME = 2'b01,
        FE_FIFO_CMD_STAT = 2'b10,
        FE_FIFO_CMD_RSVD = 2'b11
    } fe_cmd_t;

    localparam logic [7:0] RSVD_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    function automatic logic [1:0] byte_total(input logic [1:0] cmd);
        case (cmd)
            FE_FIFO_CMD_DATA: byte_total = 2'd2;
            FE_FIFO_CMD_STAT: byte_total = 2'd2;
            FE_FIFO_CMD_TIME: byte_total = 2'd3;
            default:          byte_total = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/fe_entry_encoder.sv
// Maps a FIFO entry and byte index onto the output byte, and reports how many
// bytes the entry serializes to.
module fe_entry_encoder
    import fe_fifo_reader_pkg::*;
#(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3
) (
    input  logic [ENTRY_W-1:0] entry,
    input  logic [1:0]         idx,
    output logic [7:0]         byte_out,
    output logic [1:0]         byte_cnt
);

    localparam int HDR_PAD = 6 - pTIMESTAMP_SHORT_WIDTH;

    logic [1:0]                        cmd;
    logic [pTIMESTAMP_FULL_WIDTH-1:0]  payload;
    logic [pTIMESTAMP_SHORT_WIDTH-1:0] ts;
    logic [7:0]                        hdr_short;

    assign cmd       = entry[CMD_MSB:CMD_LSB];
    assign payload   = entry[pTIMESTAMP_FULL_WIDTH-1:0];
    assign ts        = payload[pTIMESTAMP_FULL_WIDTH-1 -: pTIMESTAMP_SHORT_WIDTH];
    // DATA and STAT share a header byte carrying the short timestamp
    assign hdr_short = {cmd, ts, {HDR_PAD{1'b0}}};
    assign byte_cnt  = byte_total(cmd);

    always_comb begin
        byte_out = RSVD_BYTE;
        case (cmd)
            FE_FIFO_CMD_DATA: byte_out = (idx == 2'd0) ? hdr_short : payload[7:0];
            FE_FIFO_CMD_STAT: byte_out = (idx == 2'd0) ? hdr_short : {3'b000, payload[4:0]};
            FE_FIFO_CMD_TIME: begin
                case (idx)
                    2'd0:    byte_out = {cmd, 6'b0};
                    2'd1:    byte_out = payload[pTIMESTAMP_FULL_WIDTH-1 -: 8];
                    default: byte_out = payload[7:0];
                endcase
            end
            default:          byte_out = RSVD_BYTE;
        endcase
    end

endmodule

// File: rtl/fe_fifo_reader.sv
// Drains the front-end capture FIFO and serializes each entry into a
// ready/valid byte stream, counting fully emitted entries.
module fe_fifo_reader
    import fe_fifo_reader_pkg::*;
#(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pCOUNT_WIDTH           = 16
) (
    input  logic                    clk_usb,
    input  logic                    reset_n,
    input  logic                    I_enable,
    input  logic                    I_count_clear,
    input  logic                    I_fifo_empty,
    input  logic [17:0]             I_fifo_dout,
    output logic                    O_fifo_rd,
    output logic [7:0]              O_data,
    output logic                    O_valid,
    input  logic                    I_ready,
    output logic [pCOUNT_WIDTH-1:0] O_entry_count,
    output logic                    O_busy
);

    state_t               state, state_nxt;
    logic [ENTRY_W-1:0]   entry_r;
    logic [1:0]           idx_r;
    logic [1:0]           total_r;
    logic [ENTRY_W-1:0]   enc_entry;
    logic [1:0]           enc_idx;
    logic [7:0]           enc_byte;
    logic [1:0]           enc_total;
    logic                 fetch_ok;
    logic                 handshake;
    logic                 last_hs;
    logic                 rd_req;

    assign fetch_ok  = I_enable && !I_fifo_empty;
    assign handshake = (state == ST_EMIT) && O_valid && I_ready;
    assign last_hs   = handshake && (idx_r == total_r - 2'd1);

    // In WAIT the encoder looks at the raw FIFO word so byte 0 is registered
    // on the same edge that captures the entry; in EMIT it looks one byte ahead.
    assign enc_entry = (state == ST_WAIT) ? I_fifo_dout : entry_r;
    assign enc_idx   = (state == ST_WAIT) ? 2'd0 : idx_r + 2'd1;

    fe_entry_encoder #(
        .pTIMESTAMP_FULL_WIDTH  (pTIMESTAMP_FULL_WIDTH),
        .pTIMESTAMP_SHORT_WIDTH (pTIMESTAMP_SHORT_WIDTH)
    ) u_encoder (
        .entry    (enc_entry),
        .idx      (enc_idx),
        .byte_out (enc_byte),
        .byte_cnt (enc_total)
    );

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch_ok) begin
                    rd_req    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (last_hs) begin
                    rd_req    = fetch_ok;
                    state_nxt = fetch_ok ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read strobe is forced low while reset is held so the FIFO never pops
    assign O_fifo_rd = rd_req && reset_n;
    assign O_busy    = (state != ST_IDLE);

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_usb) begin
        if (state == ST_WAIT) entry_r <= I_fifo_dout;
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            O_valid <= 1'b0;
            O_data  <= 8'h00;
            idx_r   <= 2'd0;
            total_r <= 2'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    O_valid <= 1'b1;
                    O_data  <= enc_byte;
                    idx_r   <= 2'd0;
                    total_r <= enc_total;
                end
                ST_EMIT: begin
                    if (last_hs) begin
                        O_valid <= 1'b0;
                    end else if (handshake) begin
                        idx_r  <= idx_r + 2'd1;
                        O_data <= enc_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            O_entry_count <= '0;
        end else if (I_count_clear) begin
            O_entry_count <= '0;
        end else if (last_hs && !(&O_entry_count)) begin
            O_entry_count <= O_entry_count + {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fe_fifo_reader.sv
// Bench for fe_fifo_reader: FIFO and consumer models around the DUT, with a
// byte-level reference model derived from the entry encoding rules.
module tb_fe_fifo_reader;

    logic        clk_usb = 1'b0;
    logic        reset_n = 1'b0;
    logic        I_enable = 1'b0;
    logic        I_count_clear = 1'b0;
    logic        I_fifo_empty = 1'b1;
    logic [17:0] I_fifo_dout = '0;
    logic        O_fifo_rd;
    logic [7:0]  O_data;
    logic        O_valid;
    logic        I_ready = 1'b1;
    logic [15:0] O_entry_count;
    logic        O_busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [17:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          rd_cnt, rd_overlap, rd_empty_err, stall_err, valid_cycles;
    logic        rd_prev, stall_pend;
    logic [7:0]  stall_data;

    fe_fifo_reader #(
        .pTIMESTAMP_FULL_WIDTH  (16),
        .pTIMESTAMP_SHORT_WIDTH (3),
        .pCOUNT_WIDTH           (16)
    ) dut (
        .clk_usb       (clk_usb),
        .reset_n       (reset_n),
        .I_enable      (I_enable),
        .I_count_clear (I_count_clear),
        .I_fifo_empty  (I_fifo_empty),
        .I_fifo_dout   (I_fifo_dout),
        .O_fifo_rd     (O_fifo_rd),
        .O_data        (O_data),
        .O_valid       (O_valid),
        .I_ready       (I_ready),
        .O_entry_count (O_entry_count),
        .O_busy        (O_busy)
    );

    always #5 clk_usb = ~clk_usb;

    // FIFO model: word appears on dout one cycle after the read strobe
    always @(posedge clk_usb) begin
        logic rd_now;
        rd_now = O_fifo_rd;
        if (rd_now) begin
            rd_cnt++;
            if (rd_prev) rd_overlap++;
            if (I_fifo_empty) rd_empty_err++;
        end
        rd_prev = rd_now;
        #1;
        if (rd_now && fifo_q.size() > 0) I_fifo_dout = fifo_q.pop_front();
        I_fifo_empty = (fifo_q.size() == 0);
    end

    // Consumer monitor, sampled mid-cycle
    always @(negedge clk_usb) begin
        if (O_valid && I_ready) got_q.push_back(O_data);
        if (O_valid) valid_cycles++;
        if (stall_pend && (!O_valid || O_data !== stall_data)) stall_err++;
        stall_pend = O_valid && !I_ready;
        stall_data = O_data;
    end

    task automatic tick();
        @(posedge clk_usb);
        #2;
    endtask

    task automatic push_entry(input logic [17:0] e);
        int cmd, pl, ts;
        cmd = int'(e[17:16]);
        pl  = int'(e[15:0]);
        ts  = pl / 8192;
        fifo_q.push_back(e);
        I_fifo_empty = 1'b0;
        case (cmd)
            0: begin exp_q.push_back(8'(ts * 8)); exp_q.push_back(8'(pl % 256)); end
            2: begin exp_q.push_back(8'(128 + ts * 8)); exp_q.push_back(8'(pl % 32)); end
            1: begin
                exp_q.push_back(8'h40);
                exp_q.push_back(8'(pl / 256));
                exp_q.push_back(8'(pl % 256));
            end
            default: exp_q.push_back(8'hFF);
        endcase
    endtask

    function automatic logic [17:0] rand_entry(input int cmd);
        logic [2:0]  ts;
        logic [7:0]  d;
        logic [4:0]  s;
        logic [15:0] t;
        ts = 3'($urandom);
        d  = 8'($urandom);
        s  = 5'($urandom);
        t  = 16'($urandom);
        case (cmd)
            0:       rand_entry = {2'b00, ts, 5'b0, d};
            1:       rand_entry = {2'b01, t};
            2:       rand_entry = {2'b10, ts, 8'b0, s};
            default: rand_entry = {2'b11, t};
        endcase
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        I_enable = 1'b0;
        I_count_clear = 1'b0;
        I_ready = 1'b1;
        fifo_q.delete();
        I_fifo_empty = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        rd_cnt = 0; rd_overlap = 0; rd_empty_err = 0;
        stall_err = 0; valid_cycles = 0; rd_prev = 0; stall_pend = 0;
        tick();
    endtask

    task automatic drain(output bit to);
        int n;
        n = 0;
        tick();
        while ((fifo_q.size() != 0 || O_busy) && n < 2000) begin
            tick();
            n++;
        end
        to = (n >= 2000);
    endtask

    task automatic wait_valid(output bit to);
        int n;
        n = 0;
        while (!O_valid && n < 50) begin
            tick();
            n++;
        end
        to = (n >= 50);
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        push_entry(18'h0A05A);
        I_enable = 1'b1;
        tick();
        tick();
        tests_run++;
        if (O_fifo_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_rd: got %0b want 0", O_fifo_rd); end
        tests_run++;
        if (O_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", O_valid); end
        tests_run++;
        if (O_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %0h want 0", O_data); end
        tests_run++;
        if (O_entry_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", O_entry_count); end
        tests_run++;
        if (O_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", O_busy); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_data();
        bit to;
        do_reset();
        push_entry(18'h0A05A);
        I_enable = 1'b1;
        drain(to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL single_timeout: got busy want idle"); end
        tests_run++;
        if (got_q.size() != 2) begin tests_failed++; $display("FAIL single_len: got %0d want 2", got_q.size()); end
        else begin
            tests_run++;
            if (got_q[0] !== 8'h28) begin tests_failed++; $display("FAIL single_b0: got %0h want 28", got_q[0]); end
            tests_run++;
            if (got_q[1] !== 8'h5A) begin tests_failed++; $display("FAIL single_b1: got %0h want 5a", got_q[1]); end
        end
        tests_run++;
        if (O_entry_count !== 16'd1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", O_entry_count); end
        tests_run++;
        if (valid_cycles != 2) begin tests_failed++; $display("FAIL single_valid_cycles: got %0d want 2", valid_cycles); end
        tests_run++;
        if (rd_cnt != 1) begin tests_failed++; $display("FAIL single_rd: got %0d want 1", rd_cnt); end
    endtask

    task automatic test_time_stat();
        bit to;
        do_reset();
        push_entry({2'b01, 16'h1234});
        push_entry({2'b10, 3'd7, 8'b0, 5'h15});
        I_enable = 1'b1;
        drain(to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL ts_timeout: got busy want idle"); end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL ts_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL ts_byte%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        tests_run++;
        if (O_entry_count !== 16'd2) begin tests_failed++; $display("FAIL ts_count: got %0d want 2", O_entry_count); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int vc, n;
        do_reset();
        for (int i = 0; i < 4; i++) push_entry(rand_entry(0));
        I_enable = 1'b1;
        n = 0;
        while (!O_valid && n < 20) begin @(negedge clk_usb); n++; end
        vc = 0;
        for (int i = 0; i < 12; i++) begin
            if (O_valid) vc++;
            @(negedge clk_usb);
        end
        tests_run++;
        if (vc != 8) begin tests_failed++; $display("FAIL b2b_valid_in_12: got %0d want 8", vc); end
        drain(to);
        tests_run++;
        if (got_q.size() != 8) begin tests_failed++; $display("FAIL b2b_len: got %0d want 8", got_q.size()); end
        else for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_byte%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        tests_run++;
        if (rd_cnt != 4) begin tests_failed++; $display("FAIL b2b_rd: got %0d want 4", rd_cnt); end
        tests_run++;
        if (rd_overlap != 0 || rd_empty_err != 0) begin
            tests_failed++; $display("FAIL b2b_rd_rules: got overlap %0d empty %0d want 0 0", rd_overlap, rd_empty_err);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset();
        push_entry({2'b01, 16'h1234});
        I_enable = 1'b1;
        wait_valid(to);
        tick();
        I_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_usb);
            tests_run++;
            if (O_data !== 8'h12 || O_valid !== 1'b1) begin
                tests_failed++; $display("FAIL bp_hold%0d: got %0h/%0b want 12/1", i, O_data, O_valid);
            end
            tick();
        end
        I_ready = 1'b1;
        drain(to);
        tests_run++;
        if (got_q.size() != 3) begin tests_failed++; $display("FAIL bp_len: got %0d want 3", got_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_byte%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        tests_run++;
        if (rd_cnt != 1 || stall_err != 0) begin tests_failed++; $display("FAIL bp_rd_stall: got rd %0d stall %0d want 1 0", rd_cnt, stall_err); end
    endtask

    task automatic test_enable_drop();
        bit to;
        int n;
        do_reset();
        push_entry({2'b01, 16'hBEEF});
        push_entry({2'b01, 16'hCAFE});
        I_enable = 1'b1;
        wait_valid(to);
        I_enable = 1'b0;
        n = 0;
        while (O_busy && n < 50) begin tick(); n++; end
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (O_busy !== 1'b0) begin tests_failed++; $display("FAIL endrop_busy: got %0b want 0", O_busy); end
        tests_run++;
        if (rd_cnt != 1) begin tests_failed++; $display("FAIL endrop_rd: got %0d want 1", rd_cnt); end
        tests_run++;
        if (got_q.size() != 3) begin tests_failed++; $display("FAIL endrop_len: got %0d want 3", got_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL endrop_byte%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        tests_run++;
        if (O_entry_count !== 16'd1) begin tests_failed++; $display("FAIL endrop_count: got %0d want 1", O_entry_count); end
        I_enable = 1'b1;
        drain(to);
        tests_run++;
        if (got_q.size() != 6 || got_q[5] !== exp_q[5]) begin
            tests_failed++; $display("FAIL endrop_resume: got %0d bytes want 6", got_q.size());
        end
    endtask

    task automatic test_count_clear();
        bit to;
        do_reset();
        push_entry(rand_entry(0));
        I_enable = 1'b1;
        drain(to);
        tests_run++;
        if (O_entry_count !== 16'd1) begin tests_failed++; $display("FAIL clr_pre: got %0d want 1", O_entry_count); end
        push_entry(rand_entry(2));
        wait_valid(to);
        tick();
        I_count_clear = 1'b1;
        tick();
        I_count_clear = 1'b0;
        tests_run++;
        if (O_entry_count !== 16'd0) begin tests_failed++; $display("FAIL clr_same_cycle: got %0d want 0", O_entry_count); end
        tests_run++;
        if (got_q.size() != 4 || got_q[3] !== exp_q[3]) begin tests_failed++; $display("FAIL clr_bytes: got %0d bytes want 4", got_q.size()); end
        push_entry(rand_entry(1));
        drain(to);
        tests_run++;
        if (O_entry_count !== 16'd1) begin tests_failed++; $display("FAIL clr_post: got %0d want 1", O_entry_count); end
    endtask

    task automatic test_reserved();
        bit to;
        do_reset();
        push_entry(rand_entry(3));
        I_enable = 1'b1;
        drain(to);
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 8'hFF) begin
            tests_failed++; $display("FAIL rsvd_byte: got %0d bytes first %0h want 1 ff", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
        end
        tests_run++;
        if (O_entry_count !== 16'd1) begin tests_failed++; $display("FAIL rsvd_count: got %0d want 1", O_entry_count); end
    endtask

    task automatic test_random();
        int n, num;
        do_reset();
        num = 40;
        for (int i = 0; i < num; i++) push_entry(rand_entry(int'($urandom_range(0, 3))));
        I_enable = 1'b1;
        n = 0;
        while ((fifo_q.size() != 0 || O_busy) && n < 5000) begin
            I_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        I_ready = 1'b1;
        tests_run++;
        if (n >= 5000) begin tests_failed++; $display("FAIL rand_timeout: got busy want idle"); end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand_byte%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        tests_run++;
        if (O_entry_count !== 16'(num)) begin tests_failed++; $display("FAIL rand_count: got %0d want %0d", O_entry_count, num); end
        tests_run++;
        if (rd_cnt != num) begin tests_failed++; $display("FAIL rand_rd: got %0d want %0d", rd_cnt, num); end
        tests_run++;
        if (stall_err != 0 || rd_overlap != 0 || rd_empty_err != 0) begin
            tests_failed++; $display("FAIL rand_rules: got stall %0d overlap %0d empty %0d want 0 0 0", stall_err, rd_overlap, rd_empty_err);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        do_reset();
        push_entry({2'b01, 16'hABCD});
        push_entry(rand_entry(0));
        I_enable = 1'b1;
        drain(to);
        push_entry({2'b01, 16'h5678});
        wait_valid(to);
        tick();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (O_valid !== 1'b0 || O_data !== 8'h00 || O_busy !== 1'b0 || O_fifo_rd !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_outputs: got v%0b d%0h b%0b r%0b want all 0", O_valid, O_data, O_busy, O_fifo_rd);
        end
        tests_run++;
        if (O_entry_count !== 16'd0) begin tests_failed++; $display("FAIL rstmid_count: got %0d want 0", O_entry_count); end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (got_q.size() != 6 || got_q[5] !== 8'h40) begin tests_failed++; $display("FAIL rstmid_bytes: got %0d want 6", got_q.size()); end
        tests_run++;
        if (rd_cnt != 3 || O_busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_reread: got rd %0d busy %0b want 3 0", rd_cnt, O_busy); end
    endtask

    initial begin
        test_reset();
        test_single_data();
        test_time_stat();
        test_back_to_back();
        test_backpressure();
        test_enable_drop();
        test_count_clear();
        test_reserved();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
